// File: rtl/lane_drain_pkg.sv
// Shared types and lane-index helpers for the lane grid. The permutation block
// and the drain sequencer use the same definitions.
package lane_drain_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int GRID_N = 5;
    localparam int LANES  = GRID_N * GRID_N;
    localparam int IDX_W  = 5;

    // Lane k sits at x = k / N, y = k % N (y advances fastest).
    function automatic logic [2:0] lane_x(input logic [IDX_W-1:0] k);
        return 3'(k / IDX_W'(GRID_N));
    endfunction

    function automatic logic [2:0] lane_y(input logic [IDX_W-1:0] k);
        return 3'(k % IDX_W'(GRID_N));
    endfunction

endpackage

// File: rtl/lane_skid_buf.sv
// Two-entry in-order output buffer. The head entry drives dout directly, so a
// stalled consumer sees stable data.
module lane_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] tail;

    assign valid = (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            dout  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        dout  <= din;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: dout <= din;
                        2'b10: begin
                            tail  <= din;
                            count <= 2'd2;
                        end
                        2'b01: count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // A push while full never occurs; the reader's credit check forbids it.
                    if (pop) begin
                        dout <= tail;
                        if (push) tail  <= din;
                        else      count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/lane_drain.sv
// Drains the 25-lane state memory in lane order onto a push/stop stream,
// issuing reads only when the output buffer can absorb their data.
module lane_drain
    import lane_drain_pkg::*;
#(
    parameter int W = 64,
    parameter int N = GRID_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [2:0]   mrx,
    output logic [2:0]   mry,
    input  logic [W-1:0] mrd,
    output logic         mre,
    output logic         pushout,
    input  logic         stopout,
    output logic         firstout,
    output logic [W-1:0] dout
);

    localparam int NL = N * N;

    state_t           state;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] out_cnt;
    logic             rd_vld_p1;
    logic [1:0]       occ;
    logic [2:0]       level;
    logic             xfer;
    logic             last_rd;
    logic             last_xfer;

    assign xfer = pushout & ~stopout;

    // Entries held after this cycle's transfer plus the read whose data lands
    // at this edge; one more read fits only if that leaves a free slot.
    assign level = 3'(occ) + 3'(rd_vld_p1) - 3'(xfer);
    assign mre   = (state == RUN) && (level < 3'd2);

    assign mrx       = lane_x(rd_idx);
    assign mry       = lane_y(rd_idx);
    assign last_rd   = (rd_idx == IDX_W'(NL - 1));
    assign last_xfer = xfer && (out_cnt == IDX_W'(NL - 1));
    assign firstout  = pushout && (out_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_idx    <= '0;
            out_cnt   <= '0;
            rd_vld_p1 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            // p1: read data for the address issued this cycle appears on mrd next cycle
            rd_vld_p1 <= mre;
            if (xfer) out_cnt <= out_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        rd_idx  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (mre) begin
                        if (last_rd) state  <= FLUSH;
                        else         rd_idx <= rd_idx + 1'b1;
                    end
                end
                FLUSH: begin
                    if (last_xfer) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    lane_skid_buf #(.W(W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld_p1),
        .din   (mrd),
        .pop   (xfer),
        .valid (pushout),
        .dout  (dout),
        .count (occ)
    );

endmodule

// File: tb/tb_lane_drain.sv
// Directed bench for lane_drain: scenario table plus reset and back-to-back sequences.
module tb_lane_drain;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stopout = 1'b0;
    logic         busy, done, mre, pushout, firstout;
    logic [2:0]   mrx, mry;
    logic [W-1:0] mrd, dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string name;
        int    lo;
        int    hi;
        bit    rnd;
        int    restart_at;
        int    exp_done;
        int    exp_first;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    lane_drain #(.W(W), .N(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mrx      (mrx),
        .mry      (mry),
        .mrd      (mrd),
        .mre      (mre),
        .pushout  (pushout),
        .stopout  (stopout),
        .firstout (firstout),
        .dout     (dout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // State memory: lane(x,y) = 0000_00XY_0000_00XY, garbage when not read.
    always @(posedge clk)
        mrd <= mre ? {24'h0, 1'b0, mrx, 1'b0, mry, 24'h0, 1'b0, mrx, 1'b0, mry}
                   : 64'hBAD0_BAD0_BAD0_BAD0;

    function automatic logic [W-1:0] lane_val(input int k);
        logic [7:0] xy;
        xy = {4'(k / 5), 4'(k % 5)};
        return {24'h0, xy, 24'h0, xy};
    endfunction

    logic [W-1:0] got[$];
    bit           gotf[$];
    int           xfer_cnt, done_cnt, done_cyc, first_push, busy_at_done;
    int           issued, max_out, stall_viol;
    bit           prev_stall;
    logic [W-1:0] prev_dout;
    logic         prev_first;

    task automatic clear_mon();
        got.delete();
        gotf.delete();
        xfer_cnt = 0; done_cnt = 0; done_cyc = -1; first_push = -1;
        busy_at_done = -1; issued = 0; max_out = 0; stall_viol = 0;
        prev_stall = 0; prev_dout = '0; prev_first = 1'b0;
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (prev_stall && (pushout !== 1'b1 || dout !== prev_dout || firstout !== prev_first))
                stall_viol++;
            prev_stall = pushout && stopout;
            prev_dout  = dout;
            prev_first = firstout;
            if (pushout && first_push < 0) first_push = cyc;
            if (mre) issued++;
            if (pushout && !stopout) begin
                got.push_back(dout);
                gotf.push_back(firstout);
                xfer_cnt++;
            end
            if (issued - xfer_cnt > max_out) max_out = issued - xfer_cnt;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = int'(busy);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int lo, input int hi, input bit rnd, input int restart_at,
                              input int tail, output int s);
        bit restarted = 0;
        bit seen = 0;
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        s = cyc;
        chk("busy_rise", busy, 1);
        for (int j = 1; j <= 400 && !seen; j++) begin
            stopout = rnd ? 1'($urandom_range(0, 1)) : (j >= lo && j <= hi);
            start = (restart_at >= 0) && !restarted && (xfer_cnt == restart_at);
            if (start) restarted = 1;
            step();
            start = 1'b0;
            seen = done;
        end
        stopout = 1'b0;
        chk("done_seen", seen, 1);
        repeat (tail) step();
    endtask

    task automatic check_stream(input string name, input int s, input int exp_done, input int exp_first);
        int bad = 0;
        int nfirst = 0;
        for (int k = 0; k < got.size(); k++) begin
            if (got[k] !== lane_val(k)) bad++;
            if (gotf[k]) nfirst++;
        end
        chk({name, "_xfers"}, xfer_cnt, 25);
        chk({name, "_order"}, bad, 0);
        chk({name, "_first_cnt"}, nfirst, 1);
        chk({name, "_first_lane0"}, (gotf.size() > 0) ? gotf[0] : 1'b0, 1);
        chk({name, "_done_cnt"}, done_cnt, 1);
        if (exp_done >= 0) chk({name, "_done_cyc"}, done_cyc - s, exp_done);
        if (exp_first >= 0) chk({name, "_first_push"}, first_push - s, exp_first);
        chk({name, "_occupancy_gt2"}, max_out > 2, 0);
        chk({name, "_stall_stable"}, stall_viol, 0);
        chk({name, "_busy_at_done"}, busy_at_done, 0);
        chk({name, "_idle_addr"}, {mre, mrx, mry}, {1'b0, 3'd4, 3'd4});
    endtask

    initial begin
        int s, s2;
        tbl[0] = '{"stream",  1, 0,  1'b0, -1, 27,  2};
        tbl[1] = '{"stall",   3, 10, 1'b0, -1, 35,  2};
        tbl[2] = '{"random",  1, 0,  1'b1, -1, -1,  2};
        tbl[3] = '{"restart", 1, 0,  1'b0, 10, 27,  2};

        #1 rst = 1'b0;
        #1;
        chk("rst_ctrl", {busy, done, mre, pushout, firstout}, 0);
        chk("rst_dout", dout, 0);
        chk("rst_addr", {mrx, mry}, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        chk("idle_no_read", {busy, mre, pushout, done}, 0);

        for (int i = 0; i < 4; i++) begin
            run_stream(tbl[i].lo, tbl[i].hi, tbl[i].rnd, tbl[i].restart_at, 3, s);
            check_stream(tbl[i].name, s, tbl[i].exp_done, tbl[i].exp_first);
        end

        // Reset in the middle of a stream, after lane 12 has transferred.
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 100 && xfer_cnt < 13; j++) step();
        chk("mid_reached_lane12", xfer_cnt, 13);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, done, mre, pushout, firstout}, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_addr", {mrx, mry}, 0);
        repeat (2) step();
        rst = 1'b1;
        repeat (40) step();
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_no_xfer", xfer_cnt, 13);
        chk("mid_rst_idle", {busy, mre, pushout}, 0);
        run_stream(1, 0, 1'b0, -1, 3, s);
        check_stream("after_rst", s, 27, 2);

        // Start in the cycle following the done pulse.
        run_stream(1, 0, 1'b0, -1, 1, s);
        check_stream("b2b_a", s, 27, 2);
        run_stream(1, 0, 1'b0, -1, 3, s2);
        check_stream("b2b_b", s2, 27, 2);
        chk("b2b_gap", s2 - s, 29);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
